instr_fetch: RTL and testbench

//  Fetch stage directly downstream of the program counter. Consumes prog_ctr and

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage bus: PC/control in, memory load, fetched instruction out
interface instr_fetch_if #(
  parameter int D = 10,
  parameter int W = 9
) ();
  logic [D-1:0] prog_ctr;
  logic         absjump_en;
  logic         stall;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] instr;
  logic [D-1:0] instr_pc;
  logic         instr_valid;

  // Upstream / environment side: drives PC, control and memory load.
  modport master (
    output prog_ctr, absjump_en, stall, wr_en, wr_addr, wr_data,
    input  instr, instr_pc, instr_valid
  );

  // Fetch stage side.
  modport slave (
    input  prog_ctr, absjump_en, stall, wr_en, wr_addr, wr_data,
    output instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: synchronous imem read, stall/squash, HALT detect, issue count
module instr_fetch #(
  parameter int             D       = 10,
  parameter int             W       = 9,
  parameter logic [W-1:0]   HALT_OP = {W{1'b1}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  instr_fetch_if.slave  bus,
  output logic          done,
  output logic [15:0]   fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] mem [2**D];
  logic [W-1:0] instr_q;
  logic [D-1:0] instr_pc_q;
  logic         instr_valid_q;
  logic         issue, halt_issue, squash, fetch;

  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;

  // Instruction memory load port; never reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-edge control decode; squash outranks stall, stall outranks halt/fetch.
  always_comb begin
    state_nxt  = state;
    issue      = (state == RUN) && instr_valid_q && !bus.stall && !bus.absjump_en;
    halt_issue = issue && (instr_q == HALT_OP);
    squash     = (state == RUN) && bus.absjump_en;
    fetch      = (state == RUN) && !bus.absjump_en && !bus.stall && !halt_issue;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt_issue) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch output register; the memory read happens straight into instr (old data on same-address write).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      done          <= 1'b0;
    end else if (squash) begin
      instr_valid_q <= 1'b0;
    end else if (halt_issue) begin
      instr_valid_q <= 1'b0;
      done          <= 1'b1;
    end else if (fetch) begin
      instr_q       <= mem[bus.prog_ctr];
      instr_pc_q    <= bus.prog_ctr;
      instr_valid_q <= 1'b1;
    end
  end

  // Saturating count of instructions handed to decode, HALT included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (issue && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed table-driven bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] fetch_count;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_fetch_if #(.D(10), .W(9)) bus ();

  instr_fetch #(.D(10), .W(9), .HALT_OP(9'h1FF)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus.slave),
    .done        (done),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [9:0]  pc;
    logic        jump;
    logic        stall;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        chk_instr;
    logic [8:0]  e_instr;
    logic [9:0]  e_pc;
    logic        e_valid;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic s, input logic [9:0] pc, input logic j, input logic st,
                             input logic we, input logic [9:0] wa, input logic [8:0] wd,
                             input logic ci, input logic [8:0] ei, input logic [9:0] ep,
                             input logic ev, input logic ed, input logic [15:0] ec);
    vec_t r;
    r.start = s; r.pc = pc; r.jump = j; r.stall = st;
    r.wr_en = we; r.wr_addr = wa; r.wr_data = wd;
    r.chk_instr = ci; r.e_instr = ei; r.e_pc = ep;
    r.e_valid = ev; r.e_done = ed; r.e_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] pc, input logic j, input logic st,
                       input logic we, input logic [9:0] wa, input logic [8:0] wd);
    start = s; bus.prog_ctr = pc; bus.absjump_en = j; bus.stall = st;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
  endtask

  task automatic step(input logic s, input logic [9:0] pc);
    drive(s, pc, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
    @(posedge clk); #1;
  endtask

  task automatic write_mem(input logic [9:0] a, input logic [8:0] d);
    drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, a, d);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic check_outs(input string tag, input vec_t r);
    if (r.chk_instr) begin
      chk({tag, " instr"}, 32'(bus.instr), 32'(r.e_instr));
      chk({tag, " instr_pc"}, 32'(bus.instr_pc), 32'(r.e_pc));
    end
    chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(r.e_valid));
    chk({tag, " done"}, 32'(done), 32'(r.e_done));
    chk({tag, " fetch_count"}, 32'(fetch_count), 32'(r.e_cnt));
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].pc, tbl[i].jump, tbl[i].stall,
            tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data);
      @(posedge clk); #1;
      check_outs($sformatf("%s[%0d]", name, i), tbl[i]);
    end
    tbl.delete();
  endtask

  initial begin
    drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
    #2 reset = 1'b0;
    #1;
    chk("rst instr", 32'(bus.instr), 32'h0);
    chk("rst instr_pc", 32'(bus.instr_pc), 32'h0);
    chk("rst instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst fetch_count", 32'(fetch_count), 32'h0);

    // Memory load while still held in reset.
    @(posedge clk); #1;
    write_mem(10'd0, 9'h011);
    write_mem(10'd1, 9'h022);
    write_mem(10'd2, 9'h033);
    write_mem(10'd3, 9'h1FF);
    write_mem(10'd5, 9'h055);
    write_mem(10'd8, 9'h0AA);
    write_mem(10'd9, 9'h0BB);
    write_mem(10'd10, 9'h1FF);
    write_mem(10'd32, 9'h020);
    write_mem(10'd1023, 9'h1AB);
    reset = 1'b1;

    // Straight-line program ending in HALT; later start is ignored.
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 9'h000, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 9'h011, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 9'h022, 1, 1, 0, 1));
    tbl.push_back(v(0, 2, 0, 0, 0, 0, 0, 1, 9'h033, 2, 1, 0, 2));
    tbl.push_back(v(0, 3, 0, 0, 0, 0, 0, 1, 9'h1FF, 3, 1, 0, 3));
    tbl.push_back(v(0, 4, 0, 0, 0, 0, 0, 1, 9'h1FF, 3, 0, 1, 4));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 9'h1FF, 3, 0, 1, 4));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 9'h1FF, 3, 0, 1, 4));
    run_table("run");

    // Stall hold, jump squash (also with stall), HALT under stall.
    do_reset();
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 9'h000, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 9'h011, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 9'h022, 1, 1, 0, 1));
    tbl.push_back(v(0, 2, 0, 1, 0, 0, 0, 1, 9'h022, 1, 1, 0, 1));
    tbl.push_back(v(0, 2, 0, 1, 0, 0, 0, 1, 9'h022, 1, 1, 0, 1));
    tbl.push_back(v(0, 2, 0, 1, 0, 0, 0, 1, 9'h022, 1, 1, 0, 1));
    tbl.push_back(v(0, 2, 0, 0, 0, 0, 0, 1, 9'h033, 2, 1, 0, 2));
    tbl.push_back(v(0, 3, 1, 0, 0, 0, 0, 0, 9'h000, 0, 0, 0, 2));
    tbl.push_back(v(0, 8, 0, 0, 0, 0, 0, 1, 9'h0AA, 8, 1, 0, 2));
    tbl.push_back(v(0, 9, 1, 1, 0, 0, 0, 0, 9'h000, 0, 0, 0, 2));
    tbl.push_back(v(0, 9, 0, 0, 0, 0, 0, 1, 9'h0BB, 9, 1, 0, 2));
    tbl.push_back(v(0, 10, 0, 0, 0, 0, 0, 1, 9'h1FF, 10, 1, 0, 3));
    tbl.push_back(v(0, 11, 0, 1, 0, 0, 0, 1, 9'h1FF, 10, 1, 0, 3));
    tbl.push_back(v(0, 11, 0, 1, 0, 0, 0, 1, 9'h1FF, 10, 1, 0, 3));
    tbl.push_back(v(0, 11, 0, 0, 0, 0, 0, 1, 9'h1FF, 10, 0, 1, 4));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 9'h1FF, 10, 0, 1, 4));
    run_table("stall_jump");

    // Asynchronous reset mid-RUN clears outputs before the next edge.
    do_reset();
    step(1'b1, 10'd0);
    step(1'b0, 10'd0);
    step(1'b0, 10'd1);
    chk("pre_async instr_valid", 32'(bus.instr_valid), 32'h1);
    reset = 1'b0;
    #2;
    chk("async instr", 32'(bus.instr), 32'h0);
    chk("async instr_pc", 32'(bus.instr_pc), 32'h0);
    chk("async instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("async done", 32'(done), 32'h0);
    chk("async fetch_count", 32'(fetch_count), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // No fetch until start, memory retained, PC wrap, same-edge write/read returns old data.
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 9'h000, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 9'h000, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 9'h000, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 9'h022, 1, 1, 0, 0));
    tbl.push_back(v(0, 1023, 0, 0, 0, 0, 0, 1, 9'h1AB, 1023, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 9'h011, 0, 1, 0, 2));
    tbl.push_back(v(0, 5, 0, 0, 1, 5, 9'h155, 1, 9'h055, 5, 1, 0, 3));
    tbl.push_back(v(0, 5, 0, 0, 0, 0, 0, 1, 9'h155, 5, 1, 0, 4));
    run_table("restart");

    // Saturation of fetch_count.
    do_reset();
    step(1'b1, 10'd32);
    for (int i = 0; i < 65535; i++) step(1'b0, 10'd32);
    chk("sat FFFE", 32'(fetch_count), 32'hFFFE);
    step(1'b0, 10'd32);
    chk("sat FFFF", 32'(fetch_count), 32'hFFFF);
    step(1'b0, 10'd32);
    step(1'b0, 10'd32);
    chk("sat hold", 32'(fetch_count), 32'hFFFF);
    chk("sat instr", 32'(bus.instr), 32'h020);
    chk("sat instr_valid", 32'(bus.instr_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
